// File: rtl/scope_renderer_pkg.sv
// scope_renderer_pkg: playfield geometry, frame states and 7-segment map shared by the scope renderer
package scope_renderer_pkg;
  localparam int X_MAX           = 255;
  localparam int Y_MAX           = 220;
  localparam int PLATE_HALFWIDTH = 15;
  localparam int BALL_DWELL      = 16;
  localparam int SEG_LEN         = 8;
  localparam int DIGIT_PITCH     = 12;
  localparam int SCORE_X0        = 100;
  localparam int SCORE_Y0        = 250;
  typedef enum logic [2:0] {S_LATCH, S_BCD, S_BALL, S_PADDLE, S_SCORE, S_BORDER} state_e;
  typedef enum logic {DIR_RIGHT, DIR_DOWN} dir_e;
  // bit 0 = segment a ... bit 6 = segment g
  localparam logic [6:0] SEG_MAP [10] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66,
                                          7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};
endpackage

// File: rtl/scope_renderer_seg7_stroker.sv
// scope_renderer_seg7_stroker: lit flag, start point and stroke direction of one 7-seg segment
module scope_renderer_seg7_stroker
  import scope_renderer_pkg::*;
(
  input  logic [3:0] digit,
  input  logic [2:0] seg,
  input  logic [7:0] ox,
  input  logic [7:0] oy,
  input  logic [3:0] step,
  output logic       lit,
  output logic [7:0] start_x,
  output logic [7:0] start_y,
  output dir_e       dir,
  output logic       last
);
  always_comb begin
    lit = SEG_MAP[digit][seg];
    start_x = seg == 3'd1 || seg == 3'd2 ? ox + 8'(SEG_LEN) : ox;
    start_y = seg == 3'd3 ? oy - 8'(2 * SEG_LEN) :
              seg == 3'd2 || seg == 3'd4 || seg == 3'd6 ? oy - 8'(SEG_LEN) : oy;
    dir = seg == 3'd0 || seg == 3'd3 || seg == 3'd6 ? DIR_RIGHT : DIR_DOWN;
    last = step == 4'(SEG_LEN);
  end
endmodule

// File: rtl/scope_renderer.sv
// scope_renderer: per-frame XY point stream (ball, paddle, score) for oscilloscope DACs.
// Define SCOPE_BORDER_EN to append a playfield border trace to every frame.
module scope_renderer
  import scope_renderer_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] x_b,
  input  logic [7:0] y_b,
  input  logic [7:0] y_p_mid,
  input  logic [7:0] score,
  output logic [7:0] dac_x,
  output logic [7:0] dac_y,
  output logic       blank,
  output logic       frame_done
);
  state_e     state;
  logic [7:0] sx, sy, smid, rem, py, cnt, y_lo, y_hi, ox, start_x, start_y;
  logic [3:0] hund, tens, step, digit;
  logic [1:0] k, first_k;
  logic [2:0] seg;
  logic       lit, last;
  dir_e       dir;
`ifdef SCOPE_BORDER_EN
  logic [7:0] bx, by;
`endif
  // paddle clipping compares in 9 bits so mid+HW cannot wrap
  always_comb begin
    y_lo = {1'b0, smid} >= 9'(PLATE_HALFWIDTH) ? smid - 8'(PLATE_HALFWIDTH) : 8'd0;
    y_hi = {1'b0, smid} <= 9'(Y_MAX - PLATE_HALFWIDTH) ? smid + 8'(PLATE_HALFWIDTH) : 8'(Y_MAX);
    first_k = hund != 4'd0 ? 2'd0 : tens != 4'd0 ? 2'd1 : 2'd2;
    digit = k == 2'd0 ? hund : k == 2'd1 ? tens : rem[3:0];
    ox = 8'(SCORE_X0) + 8'(DIGIT_PITCH) * {6'd0, k};
  end
  scope_renderer_seg7_stroker u_stroker (
    .digit  (digit),
    .seg    (seg),
    .ox     (ox),
    .oy     (8'(SCORE_Y0)),
    .step   (step),
    .lit    (lit),
    .start_x(start_x),
    .start_y(start_y),
    .dir    (dir),
    .last   (last)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_LATCH;
      dac_x <= 8'd0;
      dac_y <= 8'd0;
      blank <= 1'b1;
      frame_done <= 1'b0;
      {sx, sy, smid, rem, py, cnt} <= '0;
      {hund, tens, step, k, seg} <= '0;
`ifdef SCOPE_BORDER_EN
      {bx, by} <= '0;
`endif
    end else begin
      blank <= 1'b1;
      frame_done <= 1'b0;
      case (state)
        S_LATCH: begin
          sx <= x_b;
          sy <= y_b;
          smid <= y_p_mid;
          rem <= score;
          hund <= 4'd0;
          tens <= 4'd0;
          state <= S_BCD;
        end
        S_BCD:
          if (rem >= 8'd100) begin
            rem <= rem - 8'd100;
            hund <= hund + 4'd1;
          end else if (rem >= 8'd10) begin
            rem <= rem - 8'd10;
            tens <= tens + 4'd1;
          end else begin
            cnt <= 8'd0;
            state <= S_BALL;
          end
        S_BALL: begin
          dac_x <= sx;
          dac_y <= sy;
          blank <= 1'b0;
          cnt <= cnt + 8'd1;
          if (cnt == 8'(BALL_DWELL - 1)) begin
            py <= y_lo;
            state <= S_PADDLE;
          end
        end
        S_PADDLE: begin
          dac_x <= 8'(X_MAX);
          dac_y <= py;
          blank <= 1'b0;
          py <= py + 8'd1;
          if (py == y_hi) begin
            k <= first_k;
            seg <= 3'd0;
            step <= 4'd0;
            state <= S_SCORE;
          end
        end
        S_SCORE: begin
          dac_x <= lit && dir == DIR_RIGHT ? start_x + {4'd0, step} : start_x;
          dac_y <= lit && dir == DIR_DOWN ? start_y - {4'd0, step} : start_y;
          blank <= !lit;
          step <= lit && !last ? step + 4'd1 : 4'd0;
          if (!lit || last) begin
            seg <= seg == 3'd6 ? 3'd0 : seg + 3'd1;
            if (seg == 3'd6) begin
              k <= k + 2'd1;
              if (k == 2'd2) begin
`ifdef SCOPE_BORDER_EN
                bx <= 8'd0;
                by <= 8'd0;
                state <= S_BORDER;
`else
                frame_done <= 1'b1;
                state <= S_LATCH;
`endif
              end
            end
          end
        end
`ifdef SCOPE_BORDER_EN
        // walk bottom, right, top, left edges; the origin is not revisited
        S_BORDER: begin
          dac_x <= bx;
          dac_y <= by;
          blank <= 1'b0;
          if (by == 8'd0 && bx != 8'(X_MAX)) bx <= bx + 8'd1;
          else if (bx == 8'(X_MAX) && by != 8'(Y_MAX)) by <= by + 8'd1;
          else if (by == 8'(Y_MAX) && bx != 8'd0) bx <= bx - 8'd1;
          else by <= by - 8'd1;
          if (bx == 8'd0 && by == 8'd1) begin
            frame_done <= 1'b1;
            state <= S_LATCH;
          end
        end
`endif
        default: state <= S_LATCH;
      endcase
    end
endmodule
